// File: rtl/rd53_rx_pkg.sv
// Shared definitions for the RD53A 64b/66b lane receiver: sync header codes,
// descrambler taps and the block-lock state encoding.
package rd53_rx_pkg;

  localparam logic [1:0]  HDR_DATA   = 2'b01;
  localparam logic [1:0]  HDR_CTRL   = 2'b10;
  localparam int unsigned SCR_TAP_A  = 38;
  localparam int unsigned SCR_TAP_B  = 57;
  localparam int unsigned BLOCK_BITS = 66;

  typedef enum logic {HUNT, LOCKED} lock_state_e;

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
  endfunction

endpackage

// File: rtl/rd53_descrambler_64.sv
// Combinational step of the x^58+x^39+1 self-synchronising descrambler over one
// 64-bit payload, MSB first; the caller owns the 58-bit state register.
module rd53_descrambler_64
  import rd53_rx_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [57:0] state_i,
  output logic [63:0] data_o,
  output logic [57:0] state_o
);

  logic [57:0] s_work;

  // The state is fed with the received (scrambled) bits, not the recovered ones.
  always_comb begin
    s_work = state_i;
    data_o = '0;
    for (int i = 63; i >= 0; i--) begin
      data_o[i] = data_i[i] ^ s_work[SCR_TAP_A] ^ s_work[SCR_TAP_B];
      s_work    = {s_work[56:0], data_i[i]};
    end
    state_o = s_work;
  end

endmodule

// File: rtl/rd53_lane_rx_blocksync.sv
// RD53A lane receiver: serial 66-bit block alignment by sync-header hunting with
// bit slip, block lock with windowed error tracking, optional payload descrambling.
module rd53_lane_rx_blocksync
  import rd53_rx_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned UNLOCK_ERR = 16,
  parameter bit          DESCRAMBLE = 1'b1
) (
  input  logic        SER_CLK,
  input  logic        SER_RST_B,
  input  logic        SER_BIT,
  input  logic        SER_BIT_VLD,
  input  logic        CNT_CLR,
  output logic [63:0] DATA_O,
  output logic [1:0]  HDR_O,
  output logic        DATA_VLD_O,
  output logic        LOCKED_O,
  output logic [15:0] SLIP_CNT_O,
  output logic [15:0] HDR_ERR_CNT_O
);

  lock_state_e state_q, state_d;
  logic [64:0] sr_q, sr_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic        slip_q, slip_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [57:0] scr_q, scr_d;
  logic [63:0] data_q, data_d;
  logic [1:0]  hdr_q, hdr_d;
  logic        vld_q, vld_d;
  logic [15:0] slip_cnt_q, slip_cnt_d;
  logic [15:0] hdr_err_q, hdr_err_d;

  logic [65:0] block;
  logic        boundary;
  logic        slip_inc;
  logic        hdr_err_inc;
  logic [63:0] descr_data;
  logic [57:0] scr_next;

  assign block    = {sr_q, SER_BIT};
  // A pending slip swallows one valid bit, stretching the next block to 67 bits.
  assign boundary = SER_BIT_VLD && !slip_q && (bit_cnt_q == 7'(BLOCK_BITS - 1));

  rd53_descrambler_64 u_descrambler (
    .data_i  (block[63:0]),
    .state_i (scr_q),
    .data_o  (descr_data),
    .state_o (scr_next)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    slip_d      = slip_q;
    good_cnt_d  = good_cnt_q;
    win_cnt_d   = win_cnt_q;
    err_cnt_d   = err_cnt_q;
    scr_d       = scr_q;
    data_d      = data_q;
    hdr_d       = hdr_q;
    vld_d       = 1'b0;
    slip_inc    = 1'b0;
    hdr_err_inc = 1'b0;

    if (SER_BIT_VLD) begin
      sr_d = block[64:0];
      if (slip_q)        slip_d    = 1'b0;
      else if (boundary) bit_cnt_d = '0;
      else               bit_cnt_d = bit_cnt_q + 7'd1;
    end

    if (boundary) begin
      scr_d = scr_next;
      unique case (state_q)
        HUNT: begin
          if (hdr_valid(block[65:64])) begin
            if (good_cnt_q == 16'(LOCK_CNT - 1)) begin
              state_d    = LOCKED;
              good_cnt_d = '0;
              win_cnt_d  = '0;
              err_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + 16'd1;
            end
          end else begin
            slip_d     = 1'b1;
            good_cnt_d = '0;
            slip_inc   = 1'b1;
          end
        end
        LOCKED: begin
          if (!hdr_valid(block[65:64])) begin
            hdr_err_inc = 1'b1;
            err_cnt_d   = err_cnt_q + 16'd1;
          end
          // Unlock beats the window clear when both land on the same block.
          if (!hdr_valid(block[65:64]) && (err_cnt_q == 16'(UNLOCK_ERR - 1))) begin
            state_d    = HUNT;
            good_cnt_d = '0;
          end else begin
            vld_d  = 1'b1;
            hdr_d  = block[65:64];
            data_d = DESCRAMBLE ? descr_data : block[63:0];
            if (win_cnt_q == 16'(WINDOW - 1)) begin
              win_cnt_d = '0;
              err_cnt_d = '0;
            end else begin
              win_cnt_d = win_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (CNT_CLR)                               slip_cnt_d = '0;
    else if (slip_inc && slip_cnt_q != 16'hFFFF) slip_cnt_d = slip_cnt_q + 16'd1;
    else                                       slip_cnt_d = slip_cnt_q;

    if (CNT_CLR)                                  hdr_err_d = '0;
    else if (hdr_err_inc && hdr_err_q != 16'hFFFF) hdr_err_d = hdr_err_q + 16'd1;
    else                                          hdr_err_d = hdr_err_q;
  end

  always_ff @(posedge SER_CLK or negedge SER_RST_B) begin
    if (!SER_RST_B) begin
      state_q    <= HUNT;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      slip_q     <= 1'b0;
      good_cnt_q <= '0;
      win_cnt_q  <= '0;
      err_cnt_q  <= '0;
      scr_q      <= '0;
      data_q     <= '0;
      hdr_q      <= '0;
      vld_q      <= 1'b0;
      slip_cnt_q <= '0;
      hdr_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      slip_q     <= slip_d;
      good_cnt_q <= good_cnt_d;
      win_cnt_q  <= win_cnt_d;
      err_cnt_q  <= err_cnt_d;
      scr_q      <= scr_d;
      data_q     <= data_d;
      hdr_q      <= hdr_d;
      vld_q      <= vld_d;
      slip_cnt_q <= slip_cnt_d;
      hdr_err_q  <= hdr_err_d;
    end
  end

  assign DATA_O        = data_q;
  assign HDR_O         = hdr_q;
  assign DATA_VLD_O    = vld_q;
  assign LOCKED_O      = (state_q == LOCKED);
  assign SLIP_CNT_O    = slip_cnt_q;
  assign HDR_ERR_CNT_O = hdr_err_q;

endmodule
